// File: rtl/mips_multicycle_ctrl.sv
// Moore sequencer for the shared multicycle MIPS datapath.
// Mux selects and write enables are decoded from the state register. The FETCH write strobes also use mem_ready.
module mips_multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:5] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [0:1] alu_src_b,
  output logic [0:1] alu_op,
  output logic [0:1] pc_src,
  output logic       illegal_op,
  output logic [0:3] state
);

  // state  | meaning
  // IDLE   | after reset, all outputs idle
  // FETCH  | read instruction, PC += 4 when memory is ready
  // DECODE | register read, branch target precompute
  // MEMADR | effective address for lw/sw
  // MEMRD  | load data read, waits on mem_ready
  // MEMWB  | load writeback from MDR
  // MEMWR  | store write, waits on mem_ready
  // EXEC   | R-type ALU operation
  // ALUWB  | R-type writeback to rd
  // BRANCH | beq compare and conditional PC update
  // JUMP   | PC <- jump target
  // ADDIEX | addi ALU operation
  // ADDIWB | addi writeback to rt
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  // Plain vector so the unused encodings 13-15 remain representable.
  logic [3:0] state_q;
  logic [3:0] state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      // The IR holds the opcode stable, so it can still choose the load or store path here.
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 2'b00;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // The IR and PC load only on the cycle the instruction word arrives.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
          default:                                       illegal_op = 1'b1;
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: an instruction-path model checked every cycle, plus literal spot checks.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:5] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [0:1] alu_src_b, alu_op, pc_src;
  logic [0:3] state;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
  //  reg_write, alu_src_a, alu_src_b[2], alu_op[2], pc_src[2]}
  logic [15:0] dut_out;
  assign dut_out = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                    reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src};

  localparam logic [15:0] OUT_TAB [13] = '{
    16'b0_0_0_0_0_0_0_0_0_0_00_00_00,  // 0 idle
    16'b1_0_0_1_0_1_0_0_0_0_01_00_00,  // 1 fetch (pc_write/ir_write gated by ready)
    16'b0_0_0_0_0_0_0_0_0_0_11_00_00,  // 2 decode
    16'b0_0_0_0_0_0_0_0_0_1_10_00_00,  // 3 memadr
    16'b0_0_1_1_0_0_0_0_0_0_00_00_00,  // 4 memrd
    16'b0_0_0_0_0_0_1_0_1_0_00_00_00,  // 5 memwb
    16'b0_0_1_0_1_0_0_0_0_0_00_00_00,  // 6 memwr
    16'b0_0_0_0_0_0_0_0_0_1_00_10_00,  // 7 exec
    16'b0_0_0_0_0_0_0_1_1_0_00_00_00,  // 8 aluwb
    16'b0_1_0_0_0_0_0_0_0_1_00_01_01,  // 9 branch
    16'b1_0_0_0_0_0_0_0_0_0_00_00_10,  // 10 jump
    16'b0_0_0_0_0_0_0_0_0_1_10_00_00,  // 11 addiex
    16'b0_0_0_0_0_0_0_0_1_0_00_00_00   // 12 addiwb
  };

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model: FETCH -> DECODE, then the opcode's post-decode state list, then FETCH.
  int m_state;
  int path[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_state <= 0;
      path.delete();
    end else if (m_state == 0) begin
      m_state <= 1;
    end else if (m_state == 1) begin
      m_state <= mem_ready ? 2 : 1;
    end else if (m_state == 2) begin
      path.delete();
      case (opcode)
        6'h23:   begin path.push_back(3); path.push_back(4); path.push_back(5); end
        6'h2B:   begin path.push_back(3); path.push_back(6); end
        6'h00:   begin path.push_back(7); path.push_back(8); end
        6'h04:   path.push_back(9);
        6'h02:   path.push_back(10);
        6'h08:   begin path.push_back(11); path.push_back(12); end
        default: ;
      endcase
      m_state <= (path.size() > 0) ? path.pop_front() : 1;
    end else if ((m_state == 4 || m_state == 6) && !mem_ready) begin
      m_state <= m_state;
    end else begin
      m_state <= (path.size() > 0) ? path.pop_front() : 1;
    end
  end

  always @(negedge clk) begin
    logic [15:0] exp_out;
    bit          exp_ill;
    if (chk_en) begin
      exp_out = (m_state >= 0 && m_state <= 12) ? OUT_TAB[m_state] : 16'h0;
      if (m_state == 1 && !mem_ready) begin
        exp_out[15] = 1'b0;
        exp_out[10] = 1'b0;
      end
      exp_ill = (m_state == 2) && !(opcode inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08});
      n_tests++;
      if (int'(state) != m_state) begin
        n_fail++;
        $display("FAIL model_state t=%0t: got %0d expected %0d", $time, state, m_state);
      end
      n_tests++;
      if (dut_out !== exp_out) begin
        n_fail++;
        $display("FAIL model_outputs t=%0t state=%0d: got %b expected %b", $time, m_state, dut_out, exp_out);
      end
      n_tests++;
      if (illegal_op !== exp_ill) begin
        n_fail++;
        $display("FAIL model_illegal t=%0t: got %b expected %b", $time, illegal_op, exp_ill);
      end
      n_tests++;
      if ((mem_read && mem_write) || (reg_write && pc_write)) begin
        n_fail++;
        $display("FAIL exclusive_strobes t=%0t: got mr=%b mw=%b rw=%b pw=%b expected no overlap",
                 $time, mem_read, mem_write, reg_write, pc_write);
      end
    end
  end

  task automatic lit(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // Apply inputs for the current cycle, then advance to just after the next rising edge.
  task automatic step(input bit r, input logic [5:0] op, input bit rdy);
    rst_n = r;
    opcode = op;
    mem_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 6'h00;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Reset and release
    lit("reset_state", int'(state), 0);
    lit("reset_outputs", int'(dut_out), 0);
    step(1'b0, 6'h00, 1'b0);
    lit("reset_state2", int'(state), 0);
    lit("reset_illegal", int'(illegal_op), 0);
    step(1'b1, 6'h00, 1'b1);
    lit("first_fetch_state", int'(state), 1);
    lit("first_fetch_mem_read", int'(mem_read), 1);

    // Fetch stalled: no IR/PC load
    mem_ready = 1'b0;
    #1;
    lit("fetch_stall_ir_write", int'(ir_write), 0);
    lit("fetch_stall_pc_write", int'(pc_write), 0);
    step(1'b1, 6'h23, 1'b0);
    lit("fetch_stall_hold", int'(state), 1);

    // lw with ready tied high: 1,2,3,4,5,1
    lit("lw_fetch_ir_write", int'(ir_write), 0);
    step(1'b1, 6'h23, 1'b1); lit("lw_s2", int'(state), 2);
    step(1'b1, 6'h23, 1'b1); lit("lw_s3", int'(state), 3);
    step(1'b1, 6'h23, 1'b1); lit("lw_s4", int'(state), 4);
    step(1'b1, 6'h23, 1'b1); lit("lw_s5", int'(state), 5);
    lit("lw_wb_reg_write", int'(reg_write), 1);
    lit("lw_wb_mem_to_reg", int'(mem_to_reg), 1);
    step(1'b1, 6'h23, 1'b1); lit("lw_back_fetch", int'(state), 1);

    // sw with three stall cycles in MEMWR
    step(1'b1, 6'h2B, 1'b1);
    step(1'b1, 6'h2B, 1'b1);
    step(1'b1, 6'h2B, 1'b1); lit("sw_memwr", int'(state), 6);
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      lit("sw_stall_state", int'(state), 6);
      lit("sw_stall_mem_write", int'(mem_write), 1);
      lit("sw_stall_iord", int'(iord), 1);
      step(1'b1, 6'h2B, (i == 3));
    end
    lit("sw_back_fetch", int'(state), 1);

    // R-type, beq, j
    step(1'b1, 6'h00, 1'b1);
    step(1'b1, 6'h00, 1'b1); lit("r_exec", int'(state), 7);
    lit("r_alu_op", int'(alu_op), 2);
    step(1'b1, 6'h00, 1'b1); lit("r_aluwb", int'(state), 8);
    lit("r_reg_dst", int'(reg_dst), 1);
    step(1'b1, 6'h00, 1'b1); lit("r_back_fetch", int'(state), 1);
    step(1'b1, 6'h04, 1'b1);
    step(1'b1, 6'h04, 1'b1); lit("beq_branch", int'(state), 9);
    lit("beq_alu_op", int'(alu_op), 1);
    lit("beq_pc_src", int'(pc_src), 1);
    step(1'b1, 6'h04, 1'b1);
    step(1'b1, 6'h02, 1'b1);
    step(1'b1, 6'h02, 1'b1); lit("j_jump", int'(state), 10);
    lit("j_pc_src", int'(pc_src), 2);
    step(1'b1, 6'h02, 1'b1); lit("j_back_fetch", int'(state), 1);

    // addi: 11,12 then fetch
    step(1'b1, 6'h08, 1'b1);
    step(1'b1, 6'h08, 1'b1); lit("addi_ex", int'(state), 11);
    step(1'b1, 6'h08, 1'b1); lit("addi_wb", int'(state), 12);
    lit("addi_reg_dst", int'(reg_dst), 0);
    step(1'b1, 6'h08, 1'b1); lit("addi_back_fetch", int'(state), 1);

    // Unsupported opcode
    step(1'b1, 6'h3F, 1'b1); lit("ill_decode", int'(state), 2);
    lit("ill_pulse", int'(illegal_op), 1);
    lit("ill_no_writes", int'({reg_write, mem_write, pc_write}), 0);
    step(1'b1, 6'h3F, 1'b1); lit("ill_next_fetch", int'(state), 1);
    lit("ill_cleared", int'(illegal_op), 0);

    // Reset mid-store
    step(1'b1, 6'h2B, 1'b1);
    step(1'b1, 6'h2B, 1'b1);
    step(1'b1, 6'h2B, 1'b1); lit("rst_sw_memwr", int'(state), 6);
    mem_ready = 1'b0;
    #1;
    lit("rst_sw_mem_write_before", int'(mem_write), 1);
    step(1'b0, 6'h2B, 1'b0);
    lit("rst_sw_state", int'(state), 0);
    lit("rst_sw_mem_write_after", int'(mem_write), 0);
    step(1'b1, 6'h00, 1'b0); lit("rst_sw_refetch", int'(state), 1);

    // Unreachable encoding recovers to IDLE
    chk_en = 1'b0;
    rst_n = 1'b1;
    mem_ready = 1'b0;
    force dut.state_q = 4'd14;
    #1;
    lit("forced_state", int'(state), 14);
    lit("forced_outputs", int'(dut_out), 0);
    release dut.state_q;
    @(posedge clk);
    #1;
    lit("unreachable_to_idle", int'(state), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
